// File: rtl/vga_clock_pkg.sv
// Shared definitions for the vga_clock adjust-button path: button indices,
// default timing constants and the press FSM state encoding.
package vga_clock_pkg;

   localparam int BTN_HRS         = 0;
   localparam int BTN_MIN         = 1;
   localparam int BTN_SEC         = 2;
   localparam int NUM_ADJ_BUTTONS = 3;

   // Defaults sized for a 25.175 MHz pixel clock: ~10 ms debounce, ~0.5 s first repeat, ~0.1 s rate.
   localparam int ADJ_DEBOUNCE_CYC      = 250000;
   localparam int ADJ_REPEAT_DELAY_CYC  = 12500000;
   localparam int ADJ_REPEAT_PERIOD_CYC = 2500000;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HOLD   = 2'd1,
      ST_REPEAT = 2'd2
   } adj_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/adj_button_channel.sv
// One adjust-button channel: 2-FF synchroniser, debounce counter and the
// press / hold / auto-repeat FSM that produces a registered one-cycle strobe.
module adj_button_channel
   import vga_clock_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = ADJ_DEBOUNCE_CYC,
   parameter int REPEAT_DELAY    = ADJ_REPEAT_DELAY_CYC,
   parameter int REPEAT_PERIOD   = ADJ_REPEAT_PERIOD_CYC
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic btn_level,
   output logic adj_pulse
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);

   localparam logic [DW-1:0] DEB_TERM    = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] DELAY_TERM  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] PERIOD_TERM = RW'(REPEAT_PERIOD - 1);

   logic          sync_meta;
   logic          sync_btn;
   logic [DW-1:0] dcnt;
   logic [RW-1:0] rcnt;
   adj_state_t    state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_meta <= 1'b0;
         sync_btn  <= 1'b0;
      end else begin
         sync_meta <= btn_raw;
         sync_btn  <= sync_meta;
      end
   end

   // Any return to the current level restarts the count, so short glitches never flip the level.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dcnt      <= '0;
         btn_level <= 1'b0;
      end else if (sync_btn == btn_level) begin
         dcnt <= '0;
      end else if (dcnt == DEB_TERM) begin
         dcnt      <= '0;
         btn_level <= sync_btn;
      end else begin
         dcnt <= dcnt + DW'(1);
      end
   end

   // IDLE is only ever entered with btn_level low, so seeing it high in IDLE is the rising edge.
   // Release is tested first so it always beats a coincident terminal count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         rcnt      <= '0;
         adj_pulse <= 1'b0;
      end else begin
         adj_pulse <= 1'b0;
         case (state)
            ST_IDLE: begin
               rcnt <= '0;
               if (btn_level) begin
                  adj_pulse <= 1'b1;
                  state     <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (!btn_level) begin
                  rcnt  <= '0;
                  state <= ST_IDLE;
               end else if (rcnt == DELAY_TERM) begin
                  adj_pulse <= 1'b1;
                  rcnt      <= '0;
                  state     <= ST_REPEAT;
               end else begin
                  rcnt <= rcnt + RW'(1);
               end
            end
            ST_REPEAT: begin
               if (!btn_level) begin
                  rcnt  <= '0;
                  state <= ST_IDLE;
               end else if (rcnt == PERIOD_TERM) begin
                  adj_pulse <= 1'b1;
                  rcnt      <= '0;
               end else begin
                  rcnt <= rcnt + RW'(1);
               end
            end
            default: begin
               rcnt  <= '0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/adj_button_conditioner.sv
// Conditions the raw hrs/min/sec adjust pushbuttons into debounced levels and
// one-cycle adjust strobes with hold-to-repeat, one independent channel per button.
module adj_button_conditioner
   import vga_clock_pkg::*;
#(
   parameter int NUM_BUTTONS     = NUM_ADJ_BUTTONS,
   parameter int DEBOUNCE_CYCLES = ADJ_DEBOUNCE_CYC,
   parameter int REPEAT_DELAY    = ADJ_REPEAT_DELAY_CYC,
   parameter int REPEAT_PERIOD   = ADJ_REPEAT_PERIOD_CYC
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_BUTTONS-1:0] btn_raw,
   output logic [NUM_BUTTONS-1:0] btn_level,
   output logic [NUM_BUTTONS-1:0] adj_pulse
);

   for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
      adj_button_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_chan (
         .clk       (clk),
         .reset     (reset),
         .btn_raw   (btn_raw[i]),
         .btn_level (btn_level[i]),
         .adj_pulse (adj_pulse[i])
      );
   end

endmodule

// File: tb/tb_adj_button_conditioner.sv
// Self-checking bench for adj_button_conditioner with short timing constants
// (debounce 4, repeat delay 10, repeat period 5).
module tb_adj_button_conditioner;

   localparam int NB  = 3;
   localparam int DEB = 4;
   localparam int RD  = 10;
   localparam int RP  = 5;

   logic          clk;
   logic          reset;
   logic [NB-1:0] btn_raw;
   logic [NB-1:0] btn_level;
   logic [NB-1:0] adj_pulse;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [2:0] raw;
      logic [2:0] lvl;
      logic [2:0] pulse;
   } vec_t;

   vec_t vecs [33];

   adj_button_conditioner #(
      .NUM_BUTTONS     (NB),
      .DEBOUNCE_CYCLES (DEB),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .btn_raw   (btn_raw),
      .btn_level (btn_level),
      .adj_pulse (adj_pulse)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Inputs change 1ns after a rising edge; outputs are sampled at that same point.
   task automatic applyStimulus(input logic [2:0] raw);
      btn_raw = raw;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [2:0] exp_level, input logic [2:0] exp_pulse);
      checks++;
      if (btn_level !== exp_level || adj_pulse !== exp_pulse) begin
         errors++;
         $display("[TB] FAIL %s: level=%b pulse=%b, expected level=%b pulse=%b",
                  name, btn_level, adj_pulse, exp_level, exp_pulse);
      end
   endtask

   // Step j=0 is the first edge with the new raw value: level rises at j=DEB+1,
   // falls DEB+1 steps after release, and pulses land on the steps set in pulse_mask.
   task automatic runPress(input string name, input logic [2:0] chans, input int hold,
                           input int window, input logic [63:0] pulse_mask);
      for (int j = 0; j < window; j++) begin
         applyStimulus((j < hold) ? chans : 3'b000);
         checkOutput($sformatf("%s step %0d", name, j),
                     (j >= DEB + 1 && j <= hold + DEB) ? chans : 3'b000,
                     pulse_mask[j] ? chans : 3'b000);
      end
   endtask

   task automatic midCycleReset(input string name, input logic [2:0] raw);
      #3 reset = 1'b1;
      #1 checkOutput({name, " async"}, 3'b000, 3'b000);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(raw);
         checkOutput($sformatf("%s held %0d", name, k), 3'b000, 3'b000);
      end
      reset = 1'b0;
   endtask

   initial begin
      logic [63:0] first_only;
      logic [63:0] repeat_train;
      first_only   = 64'd1 << 6;
      repeat_train = (64'd1 << 6) | (64'd1 << 16) | (64'd1 << 21) | (64'd1 << 26) | (64'd1 << 31);

      // hrs press held 8 cycles then released (steps 0-17), then a glitchy min press (18-32)
      vecs[0]  = '{3'b000, 3'b000, 3'b000};
      vecs[1]  = '{3'b001, 3'b000, 3'b000};
      vecs[2]  = '{3'b001, 3'b000, 3'b000};
      vecs[3]  = '{3'b001, 3'b000, 3'b000};
      vecs[4]  = '{3'b001, 3'b000, 3'b000};
      vecs[5]  = '{3'b001, 3'b000, 3'b000};
      vecs[6]  = '{3'b001, 3'b001, 3'b000};
      vecs[7]  = '{3'b001, 3'b001, 3'b001};
      vecs[8]  = '{3'b001, 3'b001, 3'b000};
      vecs[9]  = '{3'b000, 3'b001, 3'b000};
      vecs[10] = '{3'b000, 3'b001, 3'b000};
      vecs[11] = '{3'b000, 3'b001, 3'b000};
      vecs[12] = '{3'b000, 3'b001, 3'b000};
      vecs[13] = '{3'b000, 3'b001, 3'b000};
      vecs[14] = '{3'b000, 3'b000, 3'b000};
      vecs[15] = '{3'b000, 3'b000, 3'b000};
      vecs[16] = '{3'b000, 3'b000, 3'b000};
      vecs[17] = '{3'b000, 3'b000, 3'b000};
      vecs[18] = '{3'b010, 3'b000, 3'b000};
      vecs[19] = '{3'b010, 3'b000, 3'b000};
      vecs[20] = '{3'b010, 3'b000, 3'b000};
      vecs[21] = '{3'b000, 3'b000, 3'b000};
      vecs[22] = '{3'b010, 3'b000, 3'b000};
      vecs[23] = '{3'b010, 3'b000, 3'b000};
      vecs[24] = '{3'b010, 3'b000, 3'b000};
      for (int i = 25; i < 33; i++) vecs[i] = '{3'b000, 3'b000, 3'b000};

      reset   = 1'b1;
      btn_raw = 3'b000;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset state", 3'b000, 3'b000);
      reset = 1'b0;

      $display("[TB] table: single press, release, glitch rejection");
      for (int i = 0; i < 33; i++) begin
         applyStimulus(vecs[i].raw);
         checkOutput($sformatf("table step %0d", i), vecs[i].lvl, vecs[i].pulse);
      end

      $display("[TB] async reset with all buttons held");
      runPress("all press", 3'b111, 30, 8, first_only);
      midCycleReset("all reset", 3'b111);
      runPress("after reset idle", 3'b000, 0, 10, 64'd0);

      $display("[TB] sec hold with auto-repeat");
      runPress("sec hold", 3'b100, 28, 45, repeat_train);

      $display("[TB] hrs release coincident with first repeat");
      runPress("hrs release", 3'b001, 10, 22, first_only);
      runPress("hrs repress", 3'b001, 8, 18, first_only);

      $display("[TB] paired press with reset during hold");
      runPress("pair press", 3'b011, 40, 10, first_only);
      midCycleReset("pair reset", 3'b011);
      runPress("pair after reset", 3'b011, 28, 45, repeat_train);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
